seq_detect_sched: RTL and testbench

Time-multiplexed scheduler for non-overlapping "1010" detection across several serial bit streams. It owns one shared detector next-state datapath, one 2-bit state context per channel, and round-robin arbitration between channels. Each cycle it accepts at most one bit, advances that channel's context, and reports matches with per-channel saturating counters. It sits between the serial input front-ends and the status/interrupt logic, in place of per-channel detector instances.

---
 rtl/seq_detect_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/seq_detect_sched.sv | 112 +++++++++++
 tb/tb_seq_detect_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared "1010" detector definitions: context state encoding and the
// single next-state/match step used by the scheduler and the standalone detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } state_e;

  typedef struct packed {
    state_e nxt;
    logic   match;
  } step_t;

  // A match returns to S0 so patterns never overlap.
  function automatic step_t detect_step(input state_e cur, input logic x);
    step_t r;
    r.nxt   = S0;
    r.match = 1'b0;
    case (cur)
      S0:      r.nxt = x ? S1 : S0;
      S1:      r.nxt = x ? S1 : S10;
      S10:     r.nxt = x ? S101 : S0;
      S101: begin
        r.nxt   = x ? S1 : S0;
        r.match = ~x;
      end
      default: r.nxt = S0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from rr_ptr,
// pointer moves past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx
);

  logic [CH_W-1:0] rr_ptr_r;
  logic [CH_W-1:0] cand_s;
  logic            found_s;

  // Scan requesters starting at rr_ptr; first valid one wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand_s = CH_W'((int'(rr_ptr_r) + i) % N_CH);
      if (!found_s && req[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        gnt_idx     = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer update with explicit wrap so non-power-of-two N_CH works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (advance) begin
      if (gnt_idx == CH_W'(N_CH - 1)) begin
        rr_ptr_r <= '0;
      end else begin
        rr_ptr_r <= gnt_idx + CH_W'(1);
      end
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

endmodule

// File: rtl/seq_detect_sched.sv
// Time-multiplexed "1010" detector: one shared step function, a 2-bit context
// per channel, round-robin bit acceptance and saturating per-channel match counters.
module seq_detect_sched
  import seq_detect_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int CNT_W = 8,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  in_valid,
  input  logic [N_CH-1:0]  in_bit,
  output logic [N_CH-1:0]  in_ready,
  input  logic [N_CH-1:0]  ctx_clr,
  output logic             match_valid,
  output logic [CH_W-1:0]  match_ch,
  input  logic             cnt_clr,
  input  logic [CH_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  logic [N_CH-1:0]  gnt_s;
  logic [CH_W-1:0]  gnt_idx_s;
  logic             acc_s;
  step_t            step_s;
  logic             match_s;
  state_e           ctx_r [N_CH];
  logic [CNT_W-1:0] cnt_r [N_CH];
  logic             match_valid_r;
  logic [CH_W-1:0]  match_ch_r;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .advance (acc_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign in_ready    = gnt_s;
  assign acc_s       = |gnt_s;
  assign match_valid = match_valid_r;
  assign match_ch    = match_ch_r;

  // Shared datapath: step the granted channel; a coincident ctx_clr suppresses the match.
  always_comb begin
    step_s  = detect_step(ctx_r[gnt_idx_s], in_bit[gnt_idx_s]);
    match_s = acc_s & step_s.match & ~ctx_clr[gnt_idx_s];
  end

  // Counter read port; out-of-range selects read zero.
  always_comb begin
    cnt_out = '0;
    if (int'(cnt_sel) < N_CH) begin
      cnt_out = cnt_r[cnt_sel];
    end else begin
      cnt_out = '0;
    end
  end

  // Context array: clear wins over a granted bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) ctx_r[i] <= S0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ctx_clr[i]) begin
          ctx_r[i] <= S0;
        end else if (gnt_s[i]) begin
          ctx_r[i] <= step_s.nxt;
        end else begin
          ctx_r[i] <= ctx_r[i];
        end
      end
    end
  end

  // Match pulse; channel index holds between matches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_valid_r <= 1'b0;
      match_ch_r    <= '0;
    end else begin
      match_valid_r <= match_s;
      if (match_s) begin
        match_ch_r <= gnt_idx_s;
      end else begin
        match_ch_r <= match_ch_r;
      end
    end
  end

  // Saturating counters; a global clear discards a coincident match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cnt_clr) begin
          cnt_r[i] <= '0;
        end else if (match_s && (gnt_idx_s == CH_W'(i)) && (cnt_r[i] != {CNT_W{1'b1}})) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: table vectors, directed corner sequences and
// random traffic against a bit-history reference model.
module tb_seq_detect_sched;

  localparam int N  = 4;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] in_valid = '0, in_bit = '0, ctx_clr = '0;
  logic         cnt_clr = 1'b0;
  logic [CW-1:0] cnt_sel = '0;
  logic [N-1:0] in_ready, in_ready2;
  logic         match_valid, match_valid2;
  logic [CW-1:0] match_ch, match_ch2;
  logic [7:0]   cnt_out;
  logic [1:0]   cnt_out2;

  seq_detect_sched #(.N_CH(N), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .ctx_clr(ctx_clr), .match_valid(match_valid),
    .match_ch(match_ch), .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  seq_detect_sched #(.N_CH(N), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready2), .ctx_clr(ctx_clr), .match_valid(match_valid2),
    .match_ch(match_ch2), .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_out(cnt_out2)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int m_ptr;
  logic [3:0] m_hist [N];
  int m_len [N];
  int m_cnt8 [N];
  int m_cnt2 [N];
  logic m_mv;
  int m_mch;
  int last_g;
  int sn;
  int grant_log[$];
  int mv_step[$];
  int mv_ch[$];
  bit q [N][$];

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] b;
    logic         mv;
    logic [7:0]   cnt;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_mv = 1'b0; m_mch = 0;
    for (int i = 0; i < N; i++) begin
      m_hist[i] = 4'd0; m_len[i] = 0; m_cnt8[i] = 0; m_cnt2[i] = 0;
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] b,
                      input logic [N-1:0] cc, input logic nc, input logic [CW-1:0] sel);
    int g, gi;
    logic mt;
    in_valid = v; in_bit = b; ctx_clr = cc; cnt_clr = nc; cnt_sel = sel;
    #4;
    g = model_grant(v);
    chk("in_ready", in_ready, (g < 0) ? 32'd0 : (32'd1 << g));
    chk("cnt_out_pre", cnt_out, m_cnt8[sel]);
    gi = -1;
    for (int i = 0; i < N; i++) if (in_ready[i]) gi = i;
    grant_log.push_back(gi);
    @(posedge clk);
    mt = 1'b0;
    if (g >= 0) m_ptr = (g + 1) % N;
    for (int i = 0; i < N; i++) begin
      if (cc[i]) begin
        m_len[i] = 0;
      end else if (i == g) begin
        m_hist[i] = {m_hist[i][2:0], b[i]};
        m_len[i]++;
        if (m_len[i] >= 4 && m_hist[i] == 4'b1010) begin
          mt = 1'b1;
          m_len[i] = 0;
        end
      end
    end
    m_mv = mt;
    if (mt) m_mch = g;
    if (nc) begin
      for (int i = 0; i < N; i++) begin m_cnt8[i] = 0; m_cnt2[i] = 0; end
    end else if (mt) begin
      if (m_cnt8[g] < 255) m_cnt8[g]++;
      if (m_cnt2[g] < 3) m_cnt2[g]++;
    end
    last_g = g;
    #1;
    chk("match_valid", match_valid, m_mv);
    chk("match_ch", match_ch, m_mch);
    chk("cnt_out", cnt_out, m_cnt8[sel]);
    chk("cnt_out_w2", cnt_out2, m_cnt2[sel]);
    if (match_valid) begin mv_step.push_back(sn); mv_ch.push_back(match_ch); end
    sn++;
  endtask

  task automatic do_reset();
    in_valid = '0; in_bit = '0; ctx_clr = '0; cnt_clr = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_match_valid", match_valid, 0);
    chk("rst_match_ch", match_ch, 0);
    chk("rst_cnt_out", cnt_out, 0);
    chk("rst_in_ready", in_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sn = 0;
    grant_log.delete(); mv_step.delete(); mv_ch.delete();
  endtask

  task automatic send_bits(input int ch, input string s);
    logic [N-1:0] v, b;
    for (int k = 0; k < s.len(); k++) begin
      v = N'(1) << ch;
      b = (s[k] == "1") ? v : '0;
      step(v, b, '0, 1'b0, CW'(ch));
    end
  endtask

  task automatic run_q(input int cycles);
    logic [N-1:0] v, b;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = (q[i].size() > 0);
        b[i] = v[i] ? q[i][0] : 1'b0;
      end
      step(v, b, '0, 1'b0, '0);
      if (last_g >= 0) void'(q[last_g].pop_front());
    end
  endtask

  initial begin
    int exp_sat [5];
    int exp_ord [4];
    logic [N-1:0] pv, pb, cc;
    exp_sat = '{1, 2, 3, 3, 3};
    model_reset();
    sn = 0;
    #3;
    do_reset();

    // Test 1: table of ch0 bits 1,1,0,1,0,1,0 then 1,0
    tbl[0] = '{4'b0001, 4'b0001, 1'b0, 8'd0};
    tbl[1] = '{4'b0001, 4'b0001, 1'b0, 8'd0};
    tbl[2] = '{4'b0001, 4'b0000, 1'b0, 8'd0};
    tbl[3] = '{4'b0001, 4'b0001, 1'b0, 8'd0};
    tbl[4] = '{4'b0001, 4'b0000, 1'b1, 8'd1};
    tbl[5] = '{4'b0001, 4'b0001, 1'b0, 8'd1};
    tbl[6] = '{4'b0001, 4'b0000, 1'b0, 8'd1};
    tbl[7] = '{4'b0001, 4'b0001, 1'b0, 8'd1};
    tbl[8] = '{4'b0001, 4'b0000, 1'b1, 8'd2};
    for (int k = 0; k < 9; k++) begin
      step(tbl[k].v, tbl[k].b, '0, 1'b0, '0);
      chk("tbl_ready", grant_log[k], 0);
      chk("tbl_match_valid", match_valid, tbl[k].mv);
      chk("tbl_cnt0", cnt_out, tbl[k].cnt);
      if (tbl[k].mv) chk("tbl_match_ch", match_ch, 0);
    end

    // Test 2: ch0 and ch1 interleave 1010
    do_reset();
    q[0] = '{1'b1, 1'b0, 1'b1, 1'b0};
    q[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    run_q(10);
    for (int k = 0; k < 8; k++) chk("alt_grant", grant_log[k], k % 2);
    chk("alt_nmatch", mv_step.size(), 2);
    if (mv_step.size() == 2) begin
      chk("alt_m0_step", mv_step[0], 6);
      chk("alt_m0_ch", mv_ch[0], 0);
      chk("alt_m1_step", mv_step[1], 7);
      chk("alt_m1_ch", mv_ch[1], 1);
    end
    step('0, '0, '0, 1'b0, 2'd0); chk("alt_cnt0", cnt_out, 1);
    step('0, '0, '0, 1'b0, 2'd1); chk("alt_cnt1", cnt_out, 1);

    // Test 3: four channels always valid, then drop ch2
    do_reset();
    for (int i = 0; i < N; i++) for (int k = 0; k < 12; k++) q[i].push_back(1'b0);
    run_q(8);
    for (int k = 0; k < 5; k++) chk("rr4_grant", grant_log[k], k % 4);
    q[2].delete();
    grant_log.delete();
    run_q(4);
    exp_ord = '{0, 1, 3, 0};
    for (int k = 0; k < 4; k++) chk("rr3_grant", grant_log[k], exp_ord[k]);
    for (int i = 0; i < N; i++) q[i].delete();

    // Test 4: saturation of the 2-bit counter instance
    do_reset();
    for (int r = 0; r < 5; r++) begin
      send_bits(1, "1010");
      chk("sat_match_valid", match_valid, 1);
      chk("sat_cnt_w2", cnt_out2, exp_sat[r]);
      chk("sat_cnt_w8", cnt_out, r + 1);
    end

    // Test 5: cnt_clr with match, then ctx_clr on the final 0
    do_reset();
    send_bits(0, "1010");
    send_bits(0, "101");
    step(4'b0001, 4'b0000, '0, 1'b1, '0);
    chk("clr_match_valid", match_valid, 1);
    chk("clr_cnt", cnt_out, 0);
    send_bits(0, "101");
    step(4'b0001, 4'b0000, 4'b0001, 1'b0, '0);
    chk("ctxclr_no_match", match_valid, 0);
    send_bits(0, "10");
    chk("ctxclr_s0", match_valid, 0);
    send_bits(0, "10");
    chk("ctxclr_fresh_match", match_valid, 1);

    // Test 6: reset mid-stream
    do_reset();
    send_bits(1, "1010");
    send_bits(0, "101");
    do_reset();
    step('0, '0, '0, 1'b0, 2'd1);
    chk("rst_cnt1", cnt_out, 0);
    send_bits(0, "0");
    chk("rst_no_match", match_valid, 0);
    send_bits(0, "1010");
    chk("rst_one_match", mv_step.size(), 1);

    // Random traffic with hold-until-accepted requesters
    do_reset();
    pv = '0; pb = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && ($urandom % 3 != 0)) begin
          pv[i] = 1'b1;
          pb[i] = 1'($urandom % 2);
        end
        cc[i] = ($urandom % 40 == 0);
      end
      step(pv, pb, cc, ($urandom % 60 == 0), CW'($urandom % N));
      if (last_g >= 0) pv[last_g] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
